// File: rtl/pe_noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_noc_pkg
// Purpose  : Shared types, field offsets and header extraction for the
//            PE-side NoC packet decoder.
// Revision : 1.0 - initial release
// ============================================================================
package pe_noc_pkg;

   typedef enum logic [1:0] {
      OP_MEM2PE = 2'd0,
      OP_SPK    = 2'd1,
      OP_FILT   = 2'd2,
      OP_ILL    = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HAVE_F = 3'd1,
      ST_HAVE_S = 3'd2,
      ST_START  = 3'd3,
      ST_BUSY   = 3'd4
   } state_e;

   // Offsets for the default 4-bit address / 2-bit op layout
   localparam int unsigned c_dest_lsb = 0;
   localparam int unsigned c_src_lsb  = 4;
   localparam int unsigned c_op_lsb   = 8;
   localparam int unsigned c_pay_lsb  = 10;

   // Header fields widened to the largest supported field widths
   typedef struct packed {
      logic [7:0] dest;
      logic [7:0] src;
      logic [3:0] op;
   } pkt_hdr_t;

   function automatic pkt_hdr_t get_hdr(input logic [63:0] hdr,
                                        input int unsigned addr_w,
                                        input int unsigned op_w);
      logic [63:0] a_mask;
      logic [63:0] o_mask;
      pkt_hdr_t    h;
      a_mask = (64'd1 << addr_w) - 64'd1;
      o_mask = (64'd1 << op_w) - 64'd1;
      h.dest = 8'(hdr & a_mask);
      h.src  = 8'((hdr >> addr_w) & a_mask);
      h.op   = 4'((hdr >> (2 * addr_w)) & o_mask);
      return h;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : pe_sat_counter
// Purpose  : Saturating up-counter; holds at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module pe_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pe_packet_decoder_sync.sv
`default_nettype none
// ============================================================================
// Module   : pe_packet_decoder_sync
// Purpose  : PE-side NoC packet decoder; latches filter/spike frames and
//            issues a start handshake once both are held.
//            Optional statistics counters: define PKT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pe_packet_decoder_sync
   import pe_noc_pkg::*;
#(
   parameter  int unsigned ADDR_W = 4,
   parameter  int unsigned OP_W   = 2,
   parameter  int unsigned FILT_W = 24,
   parameter  int unsigned SPK_W  = 5,
   parameter  int unsigned CNT_W  = 16,
   localparam int unsigned PKT_W  = 2 * ADDR_W + OP_W + FILT_W + SPK_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] my_addr,
   input  logic              pkt_valid,
   output logic              pkt_ready,
   input  logic [PKT_W-1:0]  pkt_data,
   output logic [FILT_W-1:0] filt_frame,
   output logic [SPK_W-1:0]  spk_frame,
   output logic              start_valid,
   input  logic              start_ready,
   input  logic              pe_done,
   output logic              err_pulse,
   output logic [ADDR_W-1:0] last_src,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int unsigned c_p = 2 * ADDR_W + OP_W;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [FILT_W-1:0] r_filt;
   logic [SPK_W-1:0]  r_spk;
   logic              r_err;
   logic [ADDR_W-1:0] r_last_src;

   pkt_hdr_t w_hdr;
   op_e      w_op;
   logic     w_accept;
   logic     w_legal;
   logic     w_take;
   logic     w_drop;

   assign w_hdr    = get_hdr(64'(pkt_data[c_p-1:0]), ADDR_W, OP_W);
   assign w_op     = op_e'(w_hdr.op[1:0]);
   assign w_accept = pkt_valid && pkt_ready;
   // Any op encoding >= 3 is treated as illegal, including wider op fields
   assign w_legal  = (w_hdr.dest == 8'(my_addr)) && (w_hdr.op < 4'd3);
   assign w_take   = w_accept && w_legal;
   assign w_drop   = w_accept && !w_legal;

   assign pkt_ready = (r_state == ST_IDLE) || (r_state == ST_HAVE_F) ||
                      (r_state == ST_HAVE_S);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_take) begin
               case (w_op)
                  OP_MEM2PE: w_state_nxt = ST_START;
                  OP_FILT:   w_state_nxt = ST_HAVE_F;
                  OP_SPK:    w_state_nxt = ST_HAVE_S;
                  default:   w_state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_HAVE_F: begin
            if (w_take && (w_op != OP_FILT)) w_state_nxt = ST_START;
         end
         ST_HAVE_S: begin
            if (w_take && (w_op != OP_SPK)) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (start_ready) w_state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            // Filter stays valid for the next timestep; only a new spike is needed
            if (pe_done) w_state_nxt = ST_HAVE_F;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt     <= '0;
         r_spk      <= '0;
         r_err      <= 1'b0;
         r_last_src <= '0;
      end else begin
         r_err <= w_drop;
         if (w_take) begin
            r_last_src <= ADDR_W'(w_hdr.src);
            if ((w_op == OP_MEM2PE) || (w_op == OP_FILT)) begin
               r_filt <= pkt_data[c_p +: FILT_W];
            end
            if (w_op == OP_MEM2PE) begin
               r_spk <= pkt_data[c_p+FILT_W +: SPK_W];
            end else if (w_op == OP_SPK) begin
               r_spk <= pkt_data[c_p +: SPK_W];
            end
         end
      end
   end

   assign filt_frame  = r_filt;
   assign spk_frame   = r_spk;
   assign start_valid = (r_state == ST_START);
   assign err_pulse   = r_err;
   assign last_src    = r_last_src;

`ifdef PKT_STATS_EN
   pe_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_take),
      .cnt (pkt_cnt)
   );

   pe_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_drop),
      .cnt (drop_cnt)
   );
`else
   assign pkt_cnt  = '0;
   assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_packet_decoder_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_packet_decoder_sync
// Purpose  : Directed self-checking bench for pe_packet_decoder_sync.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_packet_decoder_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  my_addr;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [38:0] pkt_data;
   logic [23:0] filt_frame;
   logic [4:0]  spk_frame;
   logic        start_valid;
   logic        start_ready;
   logic        pe_done;
   logic        err_pulse;
   logic [3:0]  last_src;
   logic [3:0]  pkt_cnt;
   logic [3:0]  drop_cnt;

   int errors = 0;
   int checks = 0;

`ifdef PKT_STATS_EN
   localparam logic [3:0] c_sat_exp  = 4'hF;
   localparam logic [3:0] c_drop_exp = 4'h2;
`else
   localparam logic [3:0] c_sat_exp  = 4'h0;
   localparam logic [3:0] c_drop_exp = 4'h0;
`endif

   always #5 clk = ~clk;

   pe_packet_decoder_sync #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .my_addr     (my_addr),
      .pkt_valid   (pkt_valid),
      .pkt_ready   (pkt_ready),
      .pkt_data    (pkt_data),
      .filt_frame  (filt_frame),
      .spk_frame   (spk_frame),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .pe_done     (pe_done),
      .err_pulse   (err_pulse),
      .last_src    (last_src),
      .pkt_cnt     (pkt_cnt),
      .drop_cnt    (drop_cnt)
   );

   function automatic logic [38:0] mk(input logic [3:0] d, input logic [3:0] s,
                                      input logic [1:0] op, input logic [28:0] pay);
      return {pay, op, s, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [38:0] p);
      pkt_valid = 1'b1;
      pkt_data  = p;
      tick();
      pkt_valid = 1'b0;
      pkt_data  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; pkt_valid = 1'b0; pkt_data = '0; start_ready = 1'b0; pe_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL rst_pkt_ready got=%0h exp=1", pkt_ready); end
      checks++; if (start_valid !== 1'b0) begin errors++; $display("FAIL rst_start_valid got=%0h exp=0", start_valid); end
      checks++; if (filt_frame !== 24'h0) begin errors++; $display("FAIL rst_filt got=%h exp=0", filt_frame); end
      checks++; if (spk_frame !== 5'h0) begin errors++; $display("FAIL rst_spk got=%h exp=0", spk_frame); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err_pulse); end
      checks++; if (last_src !== 4'h0) begin errors++; $display("FAIL rst_last_src got=%h exp=0", last_src); end
      checks++; if (pkt_cnt !== 4'h0 || drop_cnt !== 4'h0) begin errors++; $display("FAIL rst_cnts got=%h/%h exp=0/0", pkt_cnt, drop_cnt); end
   endtask

   task automatic test_mem2pe();
      do_reset();
      send(mk(4'h5, 4'h2, 2'd0, {5'b10110, 24'hABCDEF}));
      checks++; if (filt_frame !== 24'hABCDEF) begin errors++; $display("FAIL m2p_filt got=%h exp=abcdef", filt_frame); end
      checks++; if (spk_frame !== 5'b10110) begin errors++; $display("FAIL m2p_spk got=%b exp=10110", spk_frame); end
      checks++; if (start_valid !== 1'b1) begin errors++; $display("FAIL m2p_start_valid got=%0h exp=1", start_valid); end
      checks++; if (pkt_ready !== 1'b0) begin errors++; $display("FAIL m2p_pkt_ready got=%0h exp=0", pkt_ready); end
      checks++; if (last_src !== 4'h2) begin errors++; $display("FAIL m2p_last_src got=%h exp=2", last_src); end
      start_ready = 1'b1;
      tick();
      start_ready = 1'b0;
      checks++; if (start_valid !== 1'b0 || pkt_ready !== 1'b0) begin errors++; $display("FAIL m2p_busy got sv=%0h pr=%0h exp 0/0", start_valid, pkt_ready); end
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      checks++; if (pkt_ready !== 1'b1 || start_valid !== 1'b0) begin errors++; $display("FAIL m2p_done got pr=%0h sv=%0h exp 1/0", pkt_ready, start_valid); end
   endtask

   task automatic test_filt_then_spk();
      do_reset();
      send(mk(4'h5, 4'h3, 2'd2, {5'h0, 24'h010203}));
      checks++; if (start_valid !== 1'b0 || pkt_ready !== 1'b1) begin errors++; $display("FAIL fs_have_f got sv=%0h pr=%0h exp 0/1", start_valid, pkt_ready); end
      checks++; if (filt_frame !== 24'h010203) begin errors++; $display("FAIL fs_filt got=%h exp=010203", filt_frame); end
      send(mk(4'h5, 4'h4, 2'd1, {24'h0, 5'b00001}));
      checks++; if (start_valid !== 1'b1 || spk_frame !== 5'b00001) begin errors++; $display("FAIL fs_start got sv=%0h spk=%b exp 1/00001", start_valid, spk_frame); end
      start_ready = 1'b1;
      tick();
      start_ready = 1'b0;
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      checks++; if (pkt_ready !== 1'b1 || start_valid !== 1'b0) begin errors++; $display("FAIL fs_after_done got pr=%0h sv=%0h exp 1/0", pkt_ready, start_valid); end
      checks++; if (filt_frame !== 24'h010203 || spk_frame !== 5'b00001) begin errors++; $display("FAIL fs_retained got filt=%h spk=%b exp 010203/00001", filt_frame, spk_frame); end
      send(mk(4'h5, 4'h4, 2'd1, {24'h0, 5'b11111}));
      checks++; if (start_valid !== 1'b1 || filt_frame !== 24'h010203 || spk_frame !== 5'b11111) begin
         errors++; $display("FAIL fs_second_ts got sv=%0h filt=%h spk=%b exp 1/010203/11111", start_valid, filt_frame, spk_frame); end
   endtask

   task automatic test_drop();
      do_reset();
      send(mk(4'h7, 4'h2, 2'd0, {5'b10110, 24'hABCDEF}));
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL drop_addr_err got=%0h exp=1", err_pulse); end
      checks++; if (filt_frame !== 24'h0 || start_valid !== 1'b0 || pkt_ready !== 1'b1) begin
         errors++; $display("FAIL drop_addr_state got filt=%h sv=%0h pr=%0h exp 0/0/1", filt_frame, start_valid, pkt_ready); end
      tick();
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL drop_err_pulse_len got=%0h exp=0", err_pulse); end
      send(mk(4'h5, 4'h9, 2'd3, {5'b11111, 24'hFFFFFF}));
      checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL drop_ill_err got=%0h exp=1", err_pulse); end
      checks++; if (filt_frame !== 24'h0 || spk_frame !== 5'h0 || last_src !== 4'h0 || pkt_ready !== 1'b1) begin
         errors++; $display("FAIL drop_ill_state got filt=%h spk=%h src=%h pr=%0h exp 0/0/0/1", filt_frame, spk_frame, last_src, pkt_ready); end
      checks++; if (drop_cnt !== c_drop_exp || pkt_cnt !== 4'h0) begin errors++; $display("FAIL drop_cnts got=%h/%h exp=%h/0", drop_cnt, pkt_cnt, c_drop_exp); end
      // A spike alone must not start the PE after the drops
      send(mk(4'h5, 4'h1, 2'd1, {24'h0, 5'b00100}));
      checks++; if (start_valid !== 1'b0 || spk_frame !== 5'b00100) begin errors++; $display("FAIL drop_then_spk got sv=%0h spk=%b exp 0/00100", start_valid, spk_frame); end
   endtask

   task automatic test_backpressure();
      do_reset();
      send(mk(4'h5, 4'h1, 2'd0, {5'b00011, 24'h111111}));
      pkt_valid = 1'b1;
      pkt_data  = mk(4'h5, 4'h6, 2'd0, {5'b11100, 24'h222222});
      start_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (start_valid !== 1'b1 || pkt_ready !== 1'b0 || filt_frame !== 24'h111111 || spk_frame !== 5'b00011 || last_src !== 4'h1) begin
            errors++; $display("FAIL bp_hold%0d got sv=%0h pr=%0h filt=%h spk=%b exp 1/0/111111/00011", i, start_valid, pkt_ready, filt_frame, spk_frame); end
      end
      pkt_valid = 1'b0;
      pkt_data  = '0;
   endtask

   task automatic test_rst_in_start();
      checks++; if (start_valid !== 1'b1) begin errors++; $display("FAIL rs_pre got=%0h exp=1", start_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (start_valid !== 1'b0 || pkt_ready !== 1'b1 || filt_frame !== 24'h0 || spk_frame !== 5'h0) begin
         errors++; $display("FAIL rs_post got sv=%0h pr=%0h filt=%h spk=%h exp 0/1/0/0", start_valid, pkt_ready, filt_frame, spk_frame); end
   endtask

   task automatic test_ignored_handshakes();
      do_reset();
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      send(mk(4'h5, 4'h1, 2'd1, {24'h0, 5'b01010}));
      checks++; if (start_valid !== 1'b0 || pkt_ready !== 1'b1) begin errors++; $display("FAIL ign_pe_done got sv=%0h pr=%0h exp 0/1", start_valid, pkt_ready); end
      start_ready = 1'b1;
      tick();
      start_ready = 1'b0;
      send(mk(4'h5, 4'h1, 2'd2, {5'h0, 24'hC0FFEE}));
      checks++; if (start_valid !== 1'b1 || filt_frame !== 24'hC0FFEE) begin errors++; $display("FAIL ign_start_ready got sv=%0h filt=%h exp 1/c0ffee", start_valid, filt_frame); end
   endtask

   task automatic test_latest_wins();
      do_reset();
      send(mk(4'h5, 4'h1, 2'd2, {5'h0, 24'hAAAAAA}));
      send(mk(4'h5, 4'h8, 2'd2, {5'h0, 24'h555555}));
      checks++; if (filt_frame !== 24'h555555 || start_valid !== 1'b0 || last_src !== 4'h8) begin
         errors++; $display("FAIL lw_filt got filt=%h sv=%0h src=%h exp 555555/0/8", filt_frame, start_valid, last_src); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         send(mk(4'h5, 4'(i), 2'd2, {5'h0, 24'(i)}));
         if (i == 14) begin
            checks++; if (pkt_cnt !== c_sat_exp) begin errors++; $display("FAIL sat_at15 got=%h exp=%h", pkt_cnt, c_sat_exp); end
         end
      end
      checks++; if (pkt_cnt !== c_sat_exp) begin errors++; $display("FAIL sat_at20 got=%h exp=%h", pkt_cnt, c_sat_exp); end
      checks++; if (last_src !== 4'h3 || filt_frame !== 24'd19 || drop_cnt !== 4'h0) begin
         errors++; $display("FAIL sat_final got src=%h filt=%h drop=%h exp 3/000013/0", last_src, filt_frame, drop_cnt); end
   endtask

   initial begin
      rst = 1'b1; my_addr = 4'h5; pkt_valid = 1'b0; pkt_data = '0; start_ready = 1'b0; pe_done = 1'b0;
      test_reset();
      test_mem2pe();
      test_filt_then_spk();
      test_drop();
      test_backpressure();
      test_rst_in_start();
      test_ignored_handshakes();
      test_latest_wins();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
